div_seq: RTL and testbench

Iterative unsigned shift-subtract divider: inverse of the carry-lookahead addition path used by the factorial datapath. It accepts a dividend/divisor pair on a start pulse, produces one quotient bit per clock (MSB first), and returns quotient, remainder and a divide-by-zero flag with a done pulse. The trial subtraction is a WIDTH+1-bit add of the inverted divisor with carry-in 1, built from the team's 4-bit carry-lookahead blocks. It sits beside the multiplier in the arithmetic unit and post-processes factorial results (digit extraction, normalisation).

---
 rtl/div_seq.sv | 151 +++++++++++++++
 tb/tb_div_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Iterative unsigned shift-subtract divider, one quotient bit per clock.
// Trial subtract is a WIDTH+1-bit add of ~D with carry-in 1 over 4-bit CLA blocks.

module div_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:1] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0])
                | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c[3:1], ci};
endmodule

module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int NB = WIDTH / 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   t;
    logic [WIDTH:0]   b;
    logic [WIDTH:0]   s;
    logic [NB:0]      c;
    logic             co;
    logic [WIDTH:0]   r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             last;
    logic             unused_r_msb;

    assign t = {r[WIDTH-1:0], q[WIDTH-1]};
    assign b = {1'b1, ~d};
    assign c[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_cla
            div_cla4 u_cla (
                .a  (t[4*gi+3:4*gi]),
                .b  (b[4*gi+3:4*gi]),
                .ci (c[gi]),
                .s  (s[4*gi+3:4*gi]),
                .co (c[gi+1])
            );
        end
    endgenerate

    // Extra top bit beyond the last CLA block; its carry-out means T >= D.
    assign s[WIDTH] = t[WIDTH] ^ b[WIDTH] ^ c[NB];
    assign co = (t[WIDTH] & b[WIDTH])
              | ((t[WIDTH] ^ b[WIDTH]) & c[NB]);

    assign r_nxt = co ? s : t;
    assign q_nxt = {q[WIDTH-2:0], co};
    assign last  = (count == CW'(WIDTH - 1));

    // R never exceeds D after an iteration, so its MSB is not fed back.
    assign unused_r_msb = r[WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            count       <= '0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                EXEC: begin
                    r     <= r_nxt;
                    q     <= q_nxt;
                    count <= count + 1'b1;
                    if (last) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_nxt;
                        remainder   <= r_nxt[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                IDLE, DONE: begin
                    if (start && divisor == '0) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else if (start) begin
                        state <= EXEC;
                        busy  <= 1'b1;
                        r     <= '0;
                        q     <= dividend;
                        d     <= divisor;
                        count <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// Directed and random checks for div_seq at WIDTH=32.

module tb_div_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] dd;
        logic [W-1:0] dv;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t tbl[12];

    always #5 clk = ~clk;

    div_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the accepting edge.
    task automatic launch(input logic [W-1:0] dd,
                          input logic [W-1:0] dv);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // cyc counts negedges since the accepting edge, bounded at 100.
    task automatic wait_done(output int cyc, output int busy_n);
        cyc = 1;
        busy_n = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc;
    int bn;
    int pulses;
    int done_at;
    logic [W-1:0] rdd;
    logic [W-1:0] rdv;

    initial begin
        tbl[0]  = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        tbl[1]  = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
        tbl[2]  = '{32'd5, 32'd9, 32'd0, 32'd5, 1'b0};
        tbl[3]  = '{32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 1'b1};
        tbl[4]  = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        tbl[5]  = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
        tbl[6]  = '{32'd7, 32'd7, 32'd1, 32'd0, 1'b0};
        tbl[7]  = '{32'h80000000, 32'hFFFFFFFF, 32'd0,
                    32'h80000000, 1'b0};
        tbl[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0};
        tbl[9]  = '{32'hFFFFFFFE, 32'd2, 32'h7FFFFFFF, 32'd0, 1'b0};
        tbl[10] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1};
        tbl[11] = '{32'd3628800, 32'd10, 32'd362880, 32'd0, 1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_q", 64'(quotient), 64'd0);
        chk("rst_r", 64'(remainder), 64'd0);
        chk("rst_z", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            launch(tbl[i].dd, tbl[i].dv);
            wait_done(cyc, bn);
            chk($sformatf("v%0d_q", i), 64'(quotient), 64'(tbl[i].q));
            chk($sformatf("v%0d_r", i), 64'(remainder), 64'(tbl[i].r));
            chk($sformatf("v%0d_z", i), 64'(div_by_zero), 64'(tbl[i].z));
            chk($sformatf("v%0d_lat", i), 64'(cyc),
                tbl[i].z ? 64'd1 : 64'd33);
            chk($sformatf("v%0d_busy", i), 64'(bn),
                tbl[i].z ? 64'd0 : 64'd32);
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), 64'(done), 64'd0);
        end

        // start during EXEC must be ignored
        @(negedge clk);
        launch(32'd100, 32'd7);
        pulses = 0;
        done_at = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done === 1'b1) begin
                pulses++;
                if (done_at == 0) done_at = c;
            end
            start = (c == 5 || c == 20);
            dividend = 32'd50;
            divisor  = 32'd3;
            @(negedge clk);
        end
        start = 1'b0;
        chk("ign_pulses", 64'(pulses), 64'd1);
        chk("ign_lat", 64'(done_at), 64'd33);
        chk("ign_q", 64'(quotient), 64'd14);
        chk("ign_r", 64'(remainder), 64'd2);

        // asynchronous reset mid-EXEC
        @(negedge clk);
        launch(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_q", 64'(quotient), 64'd0);
        chk("arst_r", 64'(remainder), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("arst_nodone", 64'(pulses), 64'd0);
        launch(32'd3628800, 32'd10);
        wait_done(cyc, bn);
        chk("post_rst_q", 64'(quotient), 64'd362880);
        chk("post_rst_r", 64'(remainder), 64'd0);

        // back-to-back starts in the DONE cycle
        @(negedge clk);
        launch(32'd100, 32'd7);
        wait_done(cyc, bn);
        chk("b2b0_q", 64'(quotient), 64'd14);
        launch(32'd3628800, 32'd7);
        chk("b2b_done_end", 64'(done), 64'd0);
        chk("b2b_hold_q", 64'(quotient), 64'd14);
        chk("b2b_hold_r", 64'(remainder), 64'd2);
        wait_done(cyc, bn);
        chk("b2b1_lat", 64'(cyc), 64'd33);
        chk("b2b1_q", 64'(quotient), 64'd518400);
        chk("b2b1_r", 64'(remainder), 64'd0);
        launch(32'd1000000007, 32'd65536);
        wait_done(cyc, bn);
        chk("b2b2_lat", 64'(cyc), 64'd33);
        chk("b2b2_q", 64'(quotient), 64'd15258);
        chk("b2b2_r", 64'(remainder), 64'd51719);

        // random regression against the arithmetic invariant
        for (int i = 0; i < 500; i++) begin
            rdd = $urandom;
            rdv = $urandom >> $urandom_range(0, 31);
            if (rdv == 0) rdv = 1;
            @(negedge clk);
            launch(rdd, rdv);
            wait_done(cyc, bn);
            chk($sformatf("rnd%0d_inv", i),
                64'(quotient) * 64'(rdv) + 64'(remainder), 64'(rdd));
            chk($sformatf("rnd%0d_rlt", i),
                64'(remainder < rdv), 64'd1);
            chk($sformatf("rnd%0d_q", i), 64'(quotient), 64'(rdd / rdv));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
